// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I widths and word type
package rv32i_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - RV32I integer register file, x0 hardwired to zero
// Two combinational read ports, one synchronous write port, async active-low clear.
module register_file
    import rv32i_pkg::*;
#(
    parameter int XLEN  = rv32i_pkg::XLEN,
    parameter int NREGS = rv32i_pkg::NREGS,
    parameter int AW    = rv32i_pkg::REG_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wrt_en,
    input  logic [AW-1:0]   oprs1,
    input  logic [AW-1:0]   oprs2,
    input  logic [AW-1:0]   oprd,
    input  logic [XLEN-1:0] wrt_data,
    output logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] rs2
);

    logic [XLEN-1:0] register [0:NREGS-1];

    // Writes to x0 are dropped so entry 0 stays zero from reset onward.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                register[i] <= '0;
            end
        end else if (wrt_en && (oprd != '0)) begin
            register[oprd] <= wrt_data;
        end
    end

    // No write bypass: a same-cycle write becomes visible only after the edge.
    assign rs1 = (oprs1 == '0) ? '0 : register[oprs1];
    assign rs2 = (oprs2 == '0) ? '0 : register[oprs2];

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - randomized self-checking bench for register_file
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        wrt_en;
    logic [4:0]  oprs1;
    logic [4:0]  oprs2;
    logic [4:0]  oprd;
    logic [31:0] wrt_data;
    logic [31:0] rs1;
    logic [31:0] rs2;

    int checks;
    int failures;

    logic [31:0] model [32];

    register_file dut (
        .clk      (clk),
        .rst      (rst),
        .wrt_en   (wrt_en),
        .oprs1    (oprs1),
        .oprs2    (oprs2),
        .oprd     (oprd),
        .wrt_data (wrt_data),
        .rs1      (rs1),
        .rs2      (rs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expect_read(input int idx);
        return (idx == 0) ? 32'd0 : model[idx];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    // One write cycle: inputs set at negedge, model updated when the edge lands.
    task automatic write_cycle(input logic en, input logic [4:0] idx, input logic [31:0] data);
        @(negedge clk);
        wrt_en   = en;
        oprd     = idx;
        wrt_data = data;
        @(posedge clk);
        if (en && idx != 5'd0) model[idx] = data;
        #1;
        wrt_en = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            oprs1 = 5'(i);
            oprs2 = 5'(31 - i);
            #1;
            check($sformatf("%s_rs1_x%0d", tag, i), rs1, expect_read(i));
            check($sformatf("%s_rs2_x%0d", tag, 31 - i), rs2, expect_read(31 - i));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        wrt_en   = 1'b0;
        oprs1    = 5'd0;
        oprs2    = 5'd0;
        oprd     = 5'd0;
        wrt_data = 32'd0;
        clear_model();

        // Reset and read everything back as zero.
        repeat (2) @(posedge clk);
        oprs1 = 5'd7;
        oprs2 = 5'd31;
        #1;
        check("reset_low_rs1", rs1, 32'd0);
        check("reset_low_rs2", rs2, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        check_all("post_reset");

        // Two directed writes, then read both on separate ports.
        write_cycle(1'b1, 5'd6, 32'd9);
        write_cycle(1'b1, 5'd8, 32'd7);
        check("peek_x6", dut.register[6], 32'd9);
        check("peek_x8", dut.register[8], 32'd7);
        oprs1 = 5'd6;
        oprs2 = 5'd8;
        #1;
        check("read_x6", rs1, 32'd9);
        check("read_x8", rs2, 32'd7);

        // Read-during-write: old value before the edge, new value right after.
        @(negedge clk);
        wrt_en   = 1'b1;
        oprd     = 5'd5;
        wrt_data = 32'd11;
        oprs1    = 5'd5;
        oprs2    = 5'd5;
        #1;
        check("rdw_before", rs1, 32'd0);
        @(posedge clk);
        model[5] = 32'd11;
        #1;
        check("rdw_after_rs1", rs1, 32'd11);
        check("rdw_after_rs2", rs2, 32'd11);
        wrt_en = 1'b0;

        // Write to x0 is discarded.
        write_cycle(1'b1, 5'd0, 32'hDEADBEEF);
        oprs1 = 5'd0;
        #1;
        check("x0_read", rs1, 32'd0);
        check("x0_peek", dut.register[0], 32'd0);

        // Disabled write leaves state alone.
        write_cycle(1'b0, 5'd6, 32'd55);
        oprs1 = 5'd6;
        #1;
        check("wen0_x6", rs1, 32'd9);

        // Randomized traffic against the array model.
        for (int n = 0; n < 400; n++) begin
            logic        en;
            logic [4:0]  idx;
            logic [31:0] data;
            en   = ($urandom_range(0, 3) != 0);
            idx  = 5'($urandom_range(0, 31));
            data = $urandom();
            @(negedge clk);
            wrt_en   = en;
            oprd     = idx;
            wrt_data = data;
            oprs1    = ($urandom_range(0, 3) == 0) ? idx : 5'($urandom_range(0, 31));
            oprs2    = ($urandom_range(0, 3) == 0) ? oprs1 : 5'($urandom_range(0, 31));
            #1;
            check($sformatf("rand%0d_pre_rs1", n), rs1, expect_read(int'(oprs1)));
            check($sformatf("rand%0d_pre_rs2", n), rs2, expect_read(int'(oprs2)));
            @(posedge clk);
            if (en && idx != 5'd0) model[idx] = data;
            #1;
            check($sformatf("rand%0d_post_rs1", n), rs1, expect_read(int'(oprs1)));
            check($sformatf("rand%0d_post_rs2", n), rs2, expect_read(int'(oprs2)));
        end
        wrt_en = 1'b0;
        check_all("after_random");

        // Mid-cycle reset clears outputs without a clock edge.
        write_cycle(1'b1, 5'd12, 32'hA5A5_0001);
        @(negedge clk);
        oprs1 = 5'd12;
        oprs2 = 5'd6;
        #2;
        rst = 1'b0;
        #1;
        clear_model();
        check("midreset_rs1", rs1, 32'd0);
        check("midreset_rs2", rs2, 32'd0);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("midreset_peek_x%0d", i), dut.register[i], 32'd0);
        end

        // A write presented while reset is held across an edge must not land.
        wrt_en   = 1'b1;
        oprd     = 5'd3;
        wrt_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("reset_edge_peek_x3", dut.register[3], 32'd0);
        oprs1 = 5'd3;
        #1;
        check("reset_edge_rs1", rs1, 32'd0);
        @(negedge clk);
        wrt_en = 1'b0;
        rst    = 1'b1;
        check_all("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
